// File: rtl/opb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : opb_reg_bus_arbiter
// Brief   : Two-master round-robin OPB arbiter / sequencer with ack timeout
//           for the software-register slave bank.
// Rev     : 1.0  initial release
// ============================================================================
module opb_reg_bus_arbiter #(
    parameter int C_OPB_AWIDTH   = 32,
    parameter int C_OPB_DWIDTH   = 32,
    parameter int C_TIMEOUT      = 16,
    parameter int C_ERRCNT_WIDTH = 16
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    input  logic [0:1]                    M_request,
    input  logic [0:2*C_OPB_AWIDTH-1]     M_ABus,
    input  logic [0:2*(C_OPB_DWIDTH/8)-1] M_BE,
    input  logic [0:2*C_OPB_DWIDTH-1]     M_DBus,
    input  logic [0:1]                    M_RNW,
    output logic [0:1]                    M_grant,
    output logic [0:1]                    M_xferAck,
    output logic [0:1]                    M_errAck,
    output logic [0:1]                    M_retry,
    output logic [0:C_OPB_DWIDTH-1]       M_rdDBus,
    output logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]     OPB_BE,
    output logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
    output logic                          OPB_RNW,
    output logic                          OPB_select,
    output logic                          OPB_seqAddr,
    input  logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
    input  logic                          Sl_xferAck,
    input  logic                          Sl_errAck,
    input  logic                          Sl_retry,
    input  logic                          Sl_toutSup,
    output logic [C_ERRCNT_WIDTH-1:0]     err_count
);

    localparam int         c_BEW       = C_OPB_DWIDTH / 8;
    localparam logic [7:0] c_TOUT_LAST = 8'(C_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_XFER    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                      r_state;
    logic                        r_owner;
    logic                        r_last_owner;
    logic [7:0]                  r_tcnt;
    logic [0:1]                  r_grant;
    logic [0:C_OPB_AWIDTH-1]     r_abus;
    logic [0:c_BEW-1]            r_be;
    logic [0:C_OPB_DWIDTH-1]     r_dbus;
    logic                        r_rnw;
    logic                        r_select;
    logic [C_ERRCNT_WIDTH-1:0]   r_err_count;

    logic                        w_pick;
    logic                        w_in_xfer;
    logic                        w_timeout;
    logic                        w_retry;
    logic                        w_err;
    logic                        w_xack;
    logic                        w_done;
    logic [0:C_OPB_AWIDTH-1]     w_abus;
    logic [0:c_BEW-1]            w_be;
    logic [0:C_OPB_DWIDTH-1]     w_dbus;
    logic                        w_rnw;

    // On a tie the master that did not own the bus last time wins.
    assign w_pick = (M_request == 2'b11) ? ~r_last_owner : M_request[1];

    assign w_abus = r_owner ? M_ABus[C_OPB_AWIDTH +: C_OPB_AWIDTH] : M_ABus[0 +: C_OPB_AWIDTH];
    assign w_be   = r_owner ? M_BE[c_BEW +: c_BEW]                 : M_BE[0 +: c_BEW];
    assign w_dbus = r_owner ? M_DBus[C_OPB_DWIDTH +: C_OPB_DWIDTH] : M_DBus[0 +: C_OPB_DWIDTH];
    assign w_rnw  = r_owner ? M_RNW[1] : M_RNW[0];

    // Reset in the XFER cycle abandons the transfer without any ack pulse.
    assign w_in_xfer = (r_state == S_XFER) && !OPB_Rst;
    assign w_timeout = (r_tcnt == c_TOUT_LAST);
    assign w_retry   = w_in_xfer && Sl_retry;
    assign w_err     = w_in_xfer && !Sl_retry && (Sl_errAck || (!Sl_xferAck && w_timeout));
    assign w_xack    = w_in_xfer && !Sl_retry && Sl_xferAck;
    assign w_done    = w_retry || w_err || w_xack;

    always_comb begin
        M_xferAck = '0;
        M_errAck  = '0;
        M_retry   = '0;
        M_rdDBus  = '0;
        if (w_retry) M_retry[r_owner] = 1'b1;
        if (w_err)   M_errAck[r_owner] = 1'b1;
        if (w_xack) begin
            M_xferAck[r_owner] = 1'b1;
            if (r_rnw) M_rdDBus = Sl_DBus;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_tcnt       <= '0;
            r_grant      <= '0;
            r_abus       <= '0;
            r_be         <= '0;
            r_dbus       <= '0;
            r_rnw        <= 1'b0;
            r_select     <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_grant <= '0;
            if ((w_retry || w_err) && !(&r_err_count))
                r_err_count <= r_err_count + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (|M_request) begin
                        r_owner <= w_pick;
                        r_grant <= w_pick ? 2'b01 : 2'b10;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_abus       <= w_abus;
                    r_be         <= w_be;
                    r_rnw        <= w_rnw;
                    r_dbus       <= w_rnw ? '0 : w_dbus;
                    r_select     <= 1'b1;
                    r_last_owner <= r_owner;
                    r_tcnt       <= '0;
                    r_state      <= S_XFER;
                end
                S_XFER: begin
                    if (w_done) begin
                        r_select <= 1'b0;
                        r_dbus   <= '0;
                        r_state  <= S_RECOVER;
                    end else if (!Sl_toutSup) begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign M_grant     = r_grant;
    assign OPB_ABus    = r_abus;
    assign OPB_BE      = r_be;
    assign OPB_DBus    = r_dbus;
    assign OPB_RNW     = r_rnw;
    assign OPB_select  = r_select;
    assign OPB_seqAddr = 1'b0;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_opb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_opb_reg_bus_arbiter
// Brief   : Self-checking bench for opb_reg_bus_arbiter with a transaction-level
//           reference model of arbitration, termination and error counting.
// Rev     : 1.0  initial release
// ============================================================================
module tb_opb_reg_bus_arbiter;

    localparam int TOUT = 16;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:1]  M_request;
    logic [0:63] M_ABus;
    logic [0:7]  M_BE;
    logic [0:63] M_DBus;
    logic [0:1]  M_RNW;
    logic [0:1]  M_grant, M_xferAck, M_errAck, M_retry;
    logic [0:31] M_rdDBus, OPB_ABus, OPB_DBus, Sl_DBus;
    logic [0:3]  OPB_BE;
    logic        OPB_RNW, OPB_select, OPB_seqAddr;
    logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;

    // Model state: owner of the previous grant and expected error count.
    int exp_last;
    int exp_errs;

    // Stimulus for the current transaction.
    logic [0:31] s_addr [2];
    logic [0:31] s_wdata[2];
    logic [0:3]  s_be   [2];
    logic        s_rnw  [2];
    logic [0:31] s_rdata;

    // Observations of the last transaction.
    int          o_owner, o_grant_cyc, o_grant_multi, o_sel_start, o_sel_len;
    int          o_term_k, o_stray, o_unstable, o_seq, o_cycles;
    logic [0:31] o_abus, o_dbus, o_rd;
    logic [0:3]  o_be;
    logic        o_rnw;
    logic [0:1]  o_xack, o_eack, o_rty;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_reg_bus_arbiter dut (
        .OPB_Clk    (OPB_Clk),
        .OPB_Rst    (OPB_Rst),
        .M_request  (M_request),
        .M_ABus     (M_ABus),
        .M_BE       (M_BE),
        .M_DBus     (M_DBus),
        .M_RNW      (M_RNW),
        .M_grant    (M_grant),
        .M_xferAck  (M_xferAck),
        .M_errAck   (M_errAck),
        .M_retry    (M_retry),
        .M_rdDBus   (M_rdDBus),
        .OPB_ABus   (OPB_ABus),
        .OPB_BE     (OPB_BE),
        .OPB_DBus   (OPB_DBus),
        .OPB_RNW    (OPB_RNW),
        .OPB_select (OPB_select),
        .OPB_seqAddr(OPB_seqAddr),
        .Sl_DBus    (Sl_DBus),
        .Sl_xferAck (Sl_xferAck),
        .Sl_errAck  (Sl_errAck),
        .Sl_retry   (Sl_retry),
        .Sl_toutSup (Sl_toutSup),
        .err_count  (err_count)
    );

    task automatic randomize_stim();
        for (int m = 0; m < 2; m++) begin
            s_addr[m]  = $urandom;
            s_wdata[m] = $urandom;
            s_be[m]    = 4'($urandom);
            s_rnw[m]   = 1'($urandom_range(0, 1));
        end
        s_rdata = $urandom;
    endtask

    // Reference: who wins, which XFER cycle ends it and how, from the bus rules.
    // kind: 0 xferAck, 1 errAck, 2 retry, 3 errAck+xferAck. Toutsup covers XFER cycles 1..sup_n.
    task automatic model(input logic [0:1] req, input int ack_k, input int kind, input int sup_n,
                         output int e_owner, output int e_k, output logic [0:1] e_x,
                         output logic [0:1] e_e, output logic [0:1] e_r, output logic [0:31] e_rd);
        int tk;
        e_owner  = (req == 2'b11) ? 1 - exp_last : (req[1] ? 1 : 0);
        exp_last = e_owner;
        tk       = TOUT + sup_n;
        e_x = '0; e_e = '0; e_r = '0; e_rd = '0;
        if (ack_k > 0 && ack_k <= tk) begin
            e_k = ack_k;
            if (kind == 2) begin
                e_r[e_owner] = 1'b1; exp_errs++;
            end else begin
                if (kind == 1 || kind == 3) begin
                    e_e[e_owner] = 1'b1; exp_errs++;
                end
                if (kind == 0 || kind == 3) begin
                    e_x[e_owner] = 1'b1;
                    e_rd = s_rnw[e_owner] ? s_rdata : 32'h0;
                end
            end
        end else begin
            e_k = tk;
            e_e[e_owner] = 1'b1;
            exp_errs++;
        end
    endtask

    // Drives one transaction starting in an IDLE cycle and records what the DUT did.
    task automatic run_txn(input logic [0:1] req, input bit hold, input int ack_k,
                           input int kind, input int sup_n);
        int  c, k;
        bit  done;
        o_owner = -1; o_grant_cyc = -1; o_grant_multi = 0; o_sel_start = -1; o_sel_len = 0;
        o_term_k = -1; o_stray = 0; o_unstable = 0; o_seq = 0;
        o_xack = '0; o_eack = '0; o_rty = '0; o_rd = '0;
        o_abus = '0; o_dbus = '0; o_be = '0; o_rnw = 1'b0;
        done = 1'b0;
        for (c = 0; c < 400 && !done; c++) begin
            @(posedge OPB_Clk); #1;
            if (c == 0) begin
                M_request = req;
                M_ABus    = {s_addr[0], s_addr[1]};
                M_BE      = {s_be[0], s_be[1]};
                M_DBus    = {s_wdata[0], s_wdata[1]};
                M_RNW     = {s_rnw[0], s_rnw[1]};
            end
            if (o_term_k >= 0 && !hold) M_request = 2'b00;
            if (OPB_select && o_sel_start < 0) begin
                o_sel_start = c;
                o_abus = OPB_ABus; o_be = OPB_BE; o_dbus = OPB_DBus; o_rnw = OPB_RNW;
            end
            k = (OPB_select && o_sel_start >= 0) ? c - o_sel_start + 1 : 0;
            Sl_toutSup = (k > 0 && k <= sup_n);
            Sl_xferAck = (k > 0 && k == ack_k && (kind == 0 || kind == 3));
            Sl_errAck  = (k > 0 && k == ack_k && (kind == 1 || kind == 3));
            Sl_retry   = (k > 0 && k == ack_k && kind == 2);
            Sl_DBus    = (k > 0 && k == ack_k) ? s_rdata : 32'($urandom);
            @(negedge OPB_Clk);
            if (M_grant != 2'b00) begin
                if (o_grant_cyc >= 0 || M_grant == 2'b11) o_grant_multi++;
                if (o_grant_cyc < 0) begin
                    o_grant_cyc = c;
                    o_owner     = int'(M_grant[1]);
                end
            end
            if (OPB_select) begin
                o_sel_len++;
                if ({OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW} !== {o_abus, o_be, o_dbus, o_rnw})
                    o_unstable++;
            end
            if (OPB_seqAddr !== 1'b0) o_seq++;
            if ((M_xferAck | M_errAck | M_retry) != 2'b00) begin
                if (o_term_k < 0) begin
                    o_term_k = k;
                    o_xack = M_xferAck; o_eack = M_errAck; o_rty = M_retry; o_rd = M_rdDBus;
                end else begin
                    o_stray++;
                end
            end else if (M_rdDBus != 32'h0) begin
                o_stray++;
            end
            if (o_term_k >= 0 && !OPB_select) done = 1'b1;
        end
        o_cycles = c;
        Sl_toutSup = 1'b0; Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0;
    endtask

    task automatic test_reset();
        OPB_Rst = 1'b1; M_request = 2'b11; Sl_xferAck = 1'b1; Sl_errAck = 1'b1; Sl_retry = 1'b1;
        Sl_DBus = $urandom;
        repeat (3) @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        checks++;
        if ({M_grant, M_xferAck, M_errAck, M_retry} !== 8'h00) begin
            errors++; $display("FAIL reset_master_outs: got %h want 00", {M_grant, M_xferAck, M_errAck, M_retry});
        end
        checks++;
        if ({M_rdDBus, OPB_ABus, OPB_DBus} !== 96'h0) begin
            errors++; $display("FAIL reset_buses: got %h want 0", {M_rdDBus, OPB_ABus, OPB_DBus});
        end
        checks++;
        if ({OPB_BE, OPB_RNW, OPB_select, OPB_seqAddr} !== 7'h0) begin
            errors++; $display("FAIL reset_opb_ctrl: got %h want 0", {OPB_BE, OPB_RNW, OPB_select, OPB_seqAddr});
        end
        checks++;
        if (err_count !== 16'h0) begin
            errors++; $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
        @(posedge OPB_Clk); #1;
        OPB_Rst = 1'b0; M_request = 2'b00;
        Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0;
        exp_last = 1; exp_errs = 0;
    endtask

    task automatic test_single_read();
        int eo, ek; logic [0:1] ex, ee, er; logic [0:31] erd;
        randomize_stim();
        s_addr[0] = 32'h01010400; s_rnw[0] = 1'b1; s_rdata = 32'hDEADBEEF;
        model(2'b10, 3, 0, 0, eo, ek, ex, ee, er, erd);
        run_txn(2'b10, 1'b0, 3, 0, 0);
        checks++;
        if (o_grant_cyc !== 1 || o_owner !== 0) begin
            errors++; $display("FAIL single_grant: cycle %0d owner %0d want cycle 1 owner 0", o_grant_cyc, o_owner);
        end
        checks++;
        if (o_sel_start !== 2 || o_sel_len !== 3) begin
            errors++; $display("FAIL single_select: start %0d len %0d want start 2 len 3", o_sel_start, o_sel_len);
        end
        checks++;
        if (o_term_k !== 3 || o_xack !== 2'b10 || o_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_ack: k %0d xack %b rd %h want k 3 xack 10 rd deadbeef", o_term_k, o_xack, o_rd);
        end
        checks++;
        if (o_abus !== 32'h01010400 || o_dbus !== 32'h0 || o_rnw !== 1'b1) begin
            errors++; $display("FAIL single_opb: abus %h dbus %h rnw %b want 01010400 0 1", o_abus, o_dbus, o_rnw);
        end
    endtask

    task automatic test_contention();
        int eo, ek; logic [0:1] ex, ee, er; logic [0:31] erd;
        for (int t = 0; t < 4; t++) begin
            randomize_stim();
            model(2'b11, 1, 0, 0, eo, ek, ex, ee, er, erd);
            run_txn(2'b11, 1'b1, 1, 0, 0);
            checks++;
            if (o_owner !== eo) begin
                errors++; $display("FAIL contention_owner[%0d]: got %0d want %0d", t, o_owner, eo);
            end
            checks++;
            if (o_cycles !== 4) begin
                errors++; $display("FAIL contention_len[%0d]: got %0d cycles want 4", t, o_cycles);
            end
            checks++;
            if (o_abus !== s_addr[eo] || o_xack !== ex) begin
                errors++; $display("FAIL contention_xfer[%0d]: abus %h xack %b want %h %b", t, o_abus, o_xack, s_addr[eo], ex);
            end
        end
        @(posedge OPB_Clk); #1; M_request = 2'b00;
        repeat (4) @(posedge OPB_Clk);
    endtask

    task automatic test_timeout();
        int eo, ek; logic [0:1] ex, ee, er; logic [0:31] erd; logic [0:1] req;
        randomize_stim();
        s_addr[0] = 32'h02000000; s_addr[1] = 32'h02000000;
        req = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        model(req, 0, 0, 0, eo, ek, ex, ee, er, erd);
        run_txn(req, 1'b0, 0, 0, 0);
        checks++;
        if (o_term_k !== 16 || o_eack !== ee || o_xack !== 2'b00 || o_sel_len !== 16) begin
            errors++; $display("FAIL timeout_term: k %0d eack %b xack %b len %0d want 16 %b 00 16", o_term_k, o_eack, o_xack, o_sel_len, ee);
        end
        checks++;
        if (err_count !== 16'(exp_errs) || o_cycles !== 19) begin
            errors++; $display("FAIL timeout_count: err_count %0d cycles %0d want %0d 19", err_count, o_cycles, exp_errs);
        end
    endtask

    task automatic test_toutsup();
        int eo, ek; logic [0:1] ex, ee, er; logic [0:31] erd;
        randomize_stim();
        model(2'b10, 41, 0, 40, eo, ek, ex, ee, er, erd);
        run_txn(2'b10, 1'b0, 41, 0, 40);
        checks++;
        if (o_term_k !== 41 || o_xack !== 2'b10 || o_eack !== 2'b00 || o_rd !== erd) begin
            errors++; $display("FAIL toutsup_ack: k %0d xack %b eack %b rd %h want 41 10 00 %h", o_term_k, o_xack, o_eack, o_rd, erd);
        end
        checks++;
        if (err_count !== 16'(exp_errs)) begin
            errors++; $display("FAIL toutsup_count: got %0d want %0d", err_count, exp_errs);
        end
    endtask

    task automatic test_retry_error();
        int eo, ek, first; logic [0:1] ex, ee, er; logic [0:31] erd; logic [0:1] req;
        randomize_stim();
        model(2'b11, 2, 2, 0, eo, ek, ex, ee, er, erd);
        run_txn(2'b11, 1'b1, 2, 2, 0);
        first = o_owner;
        checks++;
        if (o_rty !== er || o_xack !== 2'b00 || o_eack !== 2'b00 || err_count !== 16'(exp_errs)) begin
            errors++; $display("FAIL retry_pulse: rty %b xack %b eack %b cnt %0d want %b 00 00 %0d", o_rty, o_xack, o_eack, err_count, er, exp_errs);
        end
        randomize_stim();
        model(2'b11, 1, 0, 0, eo, ek, ex, ee, er, erd);
        run_txn(2'b11, 1'b0, 1, 0, 0);
        checks++;
        if (o_owner !== eo || o_owner === first) begin
            errors++; $display("FAIL retry_next_owner: got %0d want %0d", o_owner, eo);
        end
        randomize_stim();
        s_rnw[0] = 1'b1; s_rnw[1] = 1'b1;
        req = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        model(req, 3, 3, 0, eo, ek, ex, ee, er, erd);
        run_txn(req, 1'b0, 3, 3, 0);
        checks++;
        if (o_xack !== ex || o_eack !== ee || o_rd !== erd) begin
            errors++; $display("FAIL err_with_xack: xack %b eack %b rd %h want %b %b %h", o_xack, o_eack, o_rd, ex, ee, erd);
        end
        checks++;
        if (err_count !== 16'(exp_errs)) begin
            errors++; $display("FAIL err_with_xack_count: got %0d want %0d", err_count, exp_errs);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int eo, ek, n; logic [0:1] ex, ee, er; logic [0:31] erd;
        logic [0:1] acks;
        randomize_stim();
        @(posedge OPB_Clk); #1;
        M_request = 2'b01; M_ABus = {s_addr[0], s_addr[1]}; M_RNW = 2'b11;
        n = 0;
        @(posedge OPB_Clk); #1;
        while (!OPB_select && n < 10) begin
            @(posedge OPB_Clk); #1; n++;
        end
        checks++;
        if (!OPB_select) begin
            errors++; $display("FAIL rstx_select: select %b want 1 within 10 cycles", OPB_select);
        end
        OPB_Rst = 1'b1; Sl_xferAck = 1'b1; Sl_errAck = 1'b1; Sl_DBus = $urandom;
        @(negedge OPB_Clk);
        acks = M_xferAck | M_errAck | M_retry;
        checks++;
        if (acks !== 2'b00 || M_rdDBus !== 32'h0) begin
            errors++; $display("FAIL rstx_no_ack: acks %b rd %h want 00 0", acks, M_rdDBus);
        end
        @(posedge OPB_Clk); #1;
        OPB_Rst = 1'b0; Sl_xferAck = 1'b0; Sl_errAck = 1'b0; M_request = 2'b00;
        @(negedge OPB_Clk);
        checks++;
        if (OPB_select !== 1'b0 || M_grant !== 2'b00 || err_count !== 16'h0 || OPB_ABus !== 32'h0) begin
            errors++; $display("FAIL rstx_cleared: sel %b grant %b cnt %0d abus %h want 0 00 0 0", OPB_select, M_grant, err_count, OPB_ABus);
        end
        exp_last = 1; exp_errs = 0;
        randomize_stim();
        model(2'b11, 1, 0, 0, eo, ek, ex, ee, er, erd);
        run_txn(2'b11, 1'b0, 1, 0, 0);
        checks++;
        if (o_owner !== 0) begin
            errors++; $display("FAIL rstx_tie_owner: got %0d want 0", o_owner);
        end
    endtask

    task automatic test_random();
        int eo, ek, ack_k, kind, sup_n; logic [0:1] ex, ee, er; logic [0:31] erd; logic [0:1] req;
        bit hold;
        logic [0:31] edbus;
        for (int t = 0; t < 30; t++) begin
            randomize_stim();
            req   = 2'($urandom_range(1, 3));
            hold  = 1'($urandom_range(0, 1));
            ack_k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
            kind  = int'($urandom_range(0, 3));
            sup_n = int'($urandom_range(0, 5));
            model(req, ack_k, kind, sup_n, eo, ek, ex, ee, er, erd);
            run_txn(req, hold, ack_k, kind, sup_n);
            edbus = s_rnw[eo] ? 32'h0 : s_wdata[eo];
            checks++;
            if (o_owner !== eo || o_grant_cyc !== 1 || o_grant_multi !== 0) begin
                errors++; $display("FAIL rand_grant[%0d]: owner %0d cyc %0d multi %0d want %0d 1 0", t, o_owner, o_grant_cyc, o_grant_multi, eo);
            end
            checks++;
            if ({o_abus, o_be, o_rnw, o_dbus} !== {s_addr[eo], s_be[eo], s_rnw[eo], edbus}) begin
                errors++; $display("FAIL rand_opb[%0d]: got %h want %h", t, {o_abus, o_be, o_rnw, o_dbus}, {s_addr[eo], s_be[eo], s_rnw[eo], edbus});
            end
            checks++;
            if (o_sel_start !== 2 || o_sel_len !== ek || o_term_k !== ek) begin
                errors++; $display("FAIL rand_len[%0d]: start %0d len %0d k %0d want 2 %0d %0d", t, o_sel_start, o_sel_len, o_term_k, ek, ek);
            end
            checks++;
            if ({o_xack, o_eack, o_rty} !== {ex, ee, er} || o_rd !== erd) begin
                errors++; $display("FAIL rand_term[%0d]: x/e/r %b rd %h want %b %h", t, {o_xack, o_eack, o_rty}, o_rd, {ex, ee, er}, erd);
            end
            checks++;
            if (o_stray !== 0 || o_unstable !== 0 || o_seq !== 0) begin
                errors++; $display("FAIL rand_clean[%0d]: stray %0d unstable %0d seq %0d want 0 0 0", t, o_stray, o_unstable, o_seq);
            end
            checks++;
            if (err_count !== 16'(exp_errs)) begin
                errors++; $display("FAIL rand_err_count[%0d]: got %0d want %0d", t, err_count, exp_errs);
            end
        end
    endtask

    initial begin
        OPB_Rst = 1'b1; M_request = '0; M_ABus = '0; M_BE = '0; M_DBus = '0; M_RNW = '0;
        Sl_DBus = '0; Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0; Sl_toutSup = 1'b0;
        exp_last = 1; exp_errs = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_toutsup();
        test_retry_error();
        test_reset_mid_xfer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opb_reg_bus_arbiter.md
Name: opb_reg_bus_arbiter

Overview:
- Two-master OPB arbiter and transaction sequencer in front of the software-register slave bank (opb_register_ppc2simulink instances and peers).
- Shares one OPB slave segment between master 0 (PPC bridge) and master 1 (debug/DMA master) with round-robin grants.
- Drives the OPB_* select/address/data strobes and routes slave acks back to the owning master.
- Enforces a transaction timeout with error termination so a missing slave never hangs the bus.

Parameters:
- C_OPB_AWIDTH, 32, address width.
- C_OPB_DWIDTH, 32, data width.
- C_TIMEOUT, 16, XFER cycles without ack before forced error (range 2..255).
- C_ERRCNT_WIDTH, 16, width of the error counter.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  synchronous, active-high reset.
- M_request  in  [0:1]  bit i = master i requests.
- M_ABus  in  [0:63]  master 0 in bits 0:31, master 1 in bits 32:63.
- M_BE  in  [0:7]  byte enables, 4 per master, same packing.
- M_DBus  in  [0:63]  write data, same packing.
- M_RNW  in  [0:1]  1 = read.
- M_grant  out  [0:1]  one-cycle grant pulse.
- M_xferAck  out  [0:1]  transfer complete to owner.
- M_errAck  out  [0:1]  error or timeout to owner.
- M_retry  out  [0:1]  retry to owner.
- M_rdDBus  out  [0:31]  read data; valid with M_xferAck.
- OPB_ABus  out  [0:31]  registered address to slaves.
- OPB_BE  out  [0:3]  registered byte enables.
- OPB_DBus  out  [0:31]  registered write data; 0 on reads.
- OPB_RNW  out  1  registered direction.
- OPB_select  out  1  transaction active.
- OPB_seqAddr  out  1  tied 0; no burst support.
- Sl_DBus  in  [0:31]  OR-ed slave read data.
- Sl_xferAck  in  1  slave ack.
- Sl_errAck  in  1  slave error.
- Sl_retry  in  1  slave retry.
- Sl_toutSup  in  1  timeout suppress.
- err_count  out  [C_ERRCNT_WIDTH-1:0]  saturating count of errAck + timeout + retry terminations.

Behaviour:
- Reset: all outputs 0; err_count 0; state IDLE; last_owner = 1, so master 0 wins the first tie.
- FSM states: IDLE, GRANT, XFER, RECOVER.
- IDLE:
  - If any M_request bit is set, pick the owner and go to GRANT.
  - Only one requester: that master wins.
  - Both requesting: the master != last_owner wins.
- GRANT (1 cycle):
  - M_grant[owner] = 1.
  - Latch owner's ABus/BE/RNW, and DBus only if RNW = 0 (else 0), into the OPB_* registers.
  - last_owner <= owner. Next state XFER.
- Latency: request sampled at edge N → grant high in cycle N+1 → OPB_select high from cycle N+2.
- XFER:
  - OPB_select = 1; OPB_* outputs held stable.
  - Timeout counter increments each cycle with Sl_toutSup = 0 and holds while Sl_toutSup = 1.
  - Counter clears on XFER entry.
- XFER termination, priority order (evaluated each cycle):
  1. Sl_retry: M_retry[owner] pulse; err_count += 1; go to RECOVER. Next tie goes to the other master via last_owner.
  2. Sl_errAck: M_errAck[owner] pulse; err_count += 1. If Sl_xferAck is also high, M_xferAck[owner] also pulses and M_rdDBus is still driven. Go to RECOVER.
  3. Sl_xferAck: M_xferAck[owner] pulse, same cycle as Sl_xferAck. M_rdDBus = Sl_DBus if RNW, else 0. Go to RECOVER.
  4. Counter reaches C_TIMEOUT−1 with no ack: M_errAck[owner] pulse; err_count += 1; go to RECOVER.
- RECOVER (1 cycle):
  - OPB_select = 0 and OPB_DBus = 0; no grants.
  - Next state IDLE. Minimum back-to-back spacing is 4 cycles per transaction.
- Acks outside XFER are ignored and M_* acks stay 0.
- M_rdDBus is 0 whenever no M_xferAck is asserted.
- err_count saturates at all-ones.
- Requests dropped mid-transaction do not abort XFER. Masters must hold their request until ack.
- OPB_Rst asserted in any state: next edge returns to IDLE with all outputs 0. A transaction in flight is abandoned silently: no ack or err pulse is generated.

Test Plan:
- Single read: M_request=01→10 (master 0), M_ABus[0:31]=0x01010400, RNW=1; slave acks 3 cycles after select with Sl_DBus=0xDEADBEEF → M_grant[0] in cycle 1, OPB_select cycles 2–4, M_xferAck[0]=1 and M_rdDBus=0xDEADBEEF in cycle 4, select low in cycle 5.
- Contention: both masters request continuously; slave acks the first XFER cycle → grants alternate 0,1,0,1; each transaction is 4 cycles; OPB_ABus alternates between the two masters' addresses.
- Timeout: unmapped address 0x02000000, no ack → M_errAck[owner] on the 16th XFER cycle; err_count=1; bus returns to IDLE.
- toutSup: Sl_toutSup high for 40 cycles, then Sl_xferAck → no errAck; xferAck delivered at cycle 41 of XFER; err_count unchanged.
- Retry/error: Sl_retry in XFER → M_retry pulse, next tie granted to other master. Sl_errAck together with Sl_xferAck → both M_errAck and M_xferAck pulse; err_count +1.
- Reset mid-XFER: OPB_Rst for 1 cycle during select → next cycle select=0, no ack pulses, err_count=0; next tie goes to master 0.
